systolic_drain: RTL and testbench

- Receive end of the systolic array's output bus. Takes the column-skewed partial-sum stream (column c of result row k arrives one cycle after column c-1) and re-aligns it into whole result rows.
- Per-column FIFOs absorb the skew and downstream backpressure. Each aligned row is presented on a valid/ready interface toward the unified buffer / writeback path.
- A small control FSM counts an expected number of rows per job and pulses done.

---
 rtl/systolic_pkg.sv | 18 +
 rtl/drain_col_fifo.sv | 52 +++++
 rtl/systolic_drain.sv | 117 +++++++++++
 tb/tb_systolic_drain.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array drain path.
// Holds FSM state encoding, psum element type and FIFO pointer width.
package systolic_pkg;

    localparam int DEF_N          = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_CNT_W      = 16;
    localparam int PTR_W          = $clog2(DEF_DEPTH);

    typedef logic [DEF_DATA_WIDTH-1:0] psum_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } drain_state_e;

endpackage

// File: rtl/drain_col_fifo.sv
// Single-column synchronous FIFO used to absorb column skew.
// Ports: clk, rst (async active-low), push_i/data_i, pop_i/data_o,
//        full_o, empty_o. A push on full is taken only if a pop
//        happens in the same cycle.
module drain_col_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB is the wrap bit used to tell full from empty.
    logic [AW:0]                 wptr_q;
    logic [AW:0]                 rptr_q;
    logic [DEPTH-1:0][DW-1:0]    mem_q;
    logic                        wr_en;
    logic                        rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign rd_en  = pop_i && !empty_o;
    assign wr_en  = push_i && (!full_o || rd_en);
    assign data_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q[AW-1:0]] <= data_i;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Re-aligns the column-skewed psum stream into whole result rows.
// Ports: cfg_start/cfg_rows arm a job; col_data/col_valid come from
//        the array bottom row; out_data/out_valid/out_ready carry
//        aligned rows; busy, done, overflow and stray report status.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic [CNT_W-1:0]               cfg_rows,
    input  logic [N-1:0][DATA_WIDTH-1:0]   col_data,
    input  logic [N-1:0]                   col_valid,
    output logic [N-1:0][DATA_WIDTH-1:0]   out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic                           stray
);

    if (DEPTH < N || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
        $error("systolic_drain: DEPTH must be a power of two >= N");
    end

    drain_state_e     state_q;
    logic [CNT_W-1:0] rows_tgt_q;
    logic [CNT_W-1:0] rows_done_q;
    logic             done_q;
    logic             overflow_q;
    logic             stray_q;

    logic             active;
    logic             fire;
    logic             ovf_hit;
    logic [N-1:0]     push;
    logic [N-1:0]     full;
    logic [N-1:0]     empty;

    assign active = (state_q == ACTIVE);
    assign push   = col_valid & {N{active}};

    for (genvar c = 0; c < N; c++) begin : g_col
        drain_col_fifo #(
            .DW    (DATA_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[c]),
            .data_i  (col_data[c]),
            .pop_i   (fire),
            .data_o  (out_data[c]),
            .full_o  (full[c]),
            .empty_o (empty[c])
        );
    end

    // A row is complete once every column holds its element.
    assign out_valid = active && (empty == '0);
    assign fire      = out_valid && out_ready;

    // Push into a full column is lost unless the row pops this cycle.
    assign ovf_hit = |(push & full & ~{N{fire}});

    assign busy     = active;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign stray    = stray_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rows_tgt_q  <= '0;
            rows_done_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        rows_tgt_q  <= (cfg_rows == '0) ?
                                       CNT_W'(1) : cfg_rows;
                        rows_done_q <= '0;
                        overflow_q  <= 1'b0;
                        stray_q     <= 1'b0;
                        state_q     <= ACTIVE;
                    end else if (|col_valid) begin
                        stray_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ovf_hit) begin
                        overflow_q <= 1'b1;
                    end
                    if (fire) begin
                        rows_done_q <= rows_done_q + 1'b1;
                        if (rows_done_q == rows_tgt_q - 1'b1) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: single row, streaming,
// backpressure, overflow, stray/config and mid-job reset.
module tb_systolic_drain;

    typedef logic [3:0][31:0] row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [15:0] cfg_rows;
    row_t        col_data;
    logic [3:0]  col_valid;
    row_t        out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        stray;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    row_t exp_rows [16];
    row_t cap_q [$];
    int   cap_cyc [$];
    int   done_cyc;
    int   stable_bad;

    always #5 clk = ~clk;

    systolic_drain dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_rows  (cfg_rows),
        .col_data  (col_data),
        .col_valid (col_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .stray     (stray)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] r);
        cfg_rows  = r;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Drives nrows skewed rows from exp_rows starting now (cycle 0),
    // holds out_ready low until cycle 'stall', records accepted rows.
    task automatic stream(input int nrows, input int stall);
        row_t pv;
        bit   hold;
        cap_q.delete();
        cap_cyc.delete();
        done_cyc   = -1;
        stable_bad = 0;
        hold       = 1'b0;
        pv         = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            col_valid = '0;
            col_data  = '0;
            for (int c = 0; c < 4; c++) begin
                if (cyc - c >= 0 && cyc - c < nrows) begin
                    col_valid[c] = 1'b1;
                    col_data[c]  = exp_rows[cyc-c][c];
                end
            end
            out_ready = (cyc >= stall);
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (out_valid === 1'b1) begin
                if (hold && out_data !== pv) stable_bad++;
                if (out_ready) begin
                    cap_q.push_back(out_data);
                    cap_cyc.push_back(cyc);
                end
            end
            hold = (out_valid === 1'b1) && !out_ready;
            pv   = out_data;
            if (done_cyc >= 0) break;
            tick();
        end
        col_valid = '0;
        col_data  = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cfg_start = 1'b0;
        cfg_rows = '0;
        col_data = '0;
        col_valid = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== '0)
            $display("FAIL rst_out_data got %h want 0", out_data);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0)
            $display("FAIL rst_busy got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (done !== 1'b0)
            $display("FAIL rst_done got %b want 0", done);
        else pass_cnt++;
        chk_cnt++;
        if (overflow !== 1'b0)
            $display("FAIL rst_overflow got %b want 0", overflow);
        else pass_cnt++;
        chk_cnt++;
        if (stray !== 1'b0)
            $display("FAIL rst_stray got %b want 0", stray);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_row();
        row_t e;
        e = {32'd40, 32'd30, 32'd20, 32'd10};
        exp_rows[0] = e;
        start_job(16'd1);
        chk_cnt++;
        if (busy !== 1'b1)
            $display("FAIL single_busy got %b want 1", busy);
        else pass_cnt++;
        stream(1, 0);
        chk_cnt++;
        if (cap_q.size() != 1 || cap_q[0] !== e)
            $display("FAIL single_data got n=%0d want %h",
                     cap_q.size(), e);
        else pass_cnt++;
        chk_cnt++;
        if (cap_cyc.size() != 1 || cap_cyc[0] != 4)
            $display("FAIL single_latency got n=%0d want cyc 4",
                     cap_cyc.size());
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc != 5)
            $display("FAIL single_done got %0d want 5", done_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0 || overflow !== 1'b0)
            $display("FAIL single_end got busy=%b ovf=%b want 0 0",
                     busy, overflow);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (done !== 1'b0)
            $display("FAIL single_done_pulse got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 6; k++)
            for (int c = 0; c < 4; c++)
                exp_rows[k][c] = 32'(16 * k + c);
        start_job(16'd6);
        stream(6, 0);
        chk_cnt++;
        if (cap_q.size() != 6)
            $display("FAIL stream_count got %0d want 6", cap_q.size());
        else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            chk_cnt++;
            if (k >= cap_q.size() || cap_q[k] !== exp_rows[k])
                $display("FAIL stream_row%0d got %h want %h",
                         k, (k < cap_q.size()) ? cap_q[k] : '0,
                         exp_rows[k]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (cap_cyc.size() != 6 || cap_cyc[0] != 4 || cap_cyc[5] != 9)
            $display("FAIL stream_timing got n=%0d want cyc 4..9",
                     cap_cyc.size());
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc != 10 || busy !== 1'b0)
            $display("FAIL stream_done got %0d busy=%b want 10 0",
                     done_cyc, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                exp_rows[k][c] = 32'h1000 + 32'(16 * k + c);
        start_job(16'd4);
        stream(4, 12);
        chk_cnt++;
        if (overflow !== 1'b0)
            $display("FAIL bp_overflow got %b want 0", overflow);
        else pass_cnt++;
        chk_cnt++;
        if (stable_bad != 0)
            $display("FAIL bp_stable got %0d changes want 0", stable_bad);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (k >= cap_q.size() || cap_q[k] !== exp_rows[k] ||
                cap_cyc[k] != 12 + k)
                $display("FAIL bp_row%0d got n=%0d want %h at cyc %0d",
                         k, cap_q.size(), exp_rows[k], 12 + k);
            else pass_cnt++;
        end
        chk_cnt++;
        if (done_cyc != 16)
            $display("FAIL bp_done got %0d want 16", done_cyc);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        row_t e;
        int   got;
        start_job(16'd8);
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                chk_cnt++;
                if (overflow !== 1'b0)
                    $display("FAIL ovf_at_full got %b want 0", overflow);
                else pass_cnt++;
            end
            col_valid   = 4'b0001;
            col_data    = '0;
            col_data[0] = 32'(100 + i);
            tick();
        end
        col_valid = '0;
        chk_cnt++;
        if (overflow !== 1'b1)
            $display("FAIL ovf_set got %b want 1", overflow);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            col_valid = 4'b1110;
            for (int c = 1; c < 4; c++)
                col_data[c] = 32'(200 + 4 * k + c);
            tick();
        end
        col_valid = '0;
        col_data  = '0;
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) begin
                e[0] = 32'(100 + got);
                for (int c = 1; c < 4; c++)
                    e[c] = 32'(200 + 4 * got + c);
                chk_cnt++;
                if (out_data !== e)
                    $display("FAIL ovf_row%0d got %h want %h",
                             got, out_data, e);
                else pass_cnt++;
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        chk_cnt++;
        if (got != 8 || busy !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_end got rows=%0d busy=%b ovf=%b want 8 0 1",
                     got, busy, overflow);
        else pass_cnt++;
    endtask

    task automatic test_stray_cfg();
        row_t e;
        col_valid = 4'b1111;
        col_data  = {4{32'd999}};
        tick();
        col_valid = '0;
        col_data  = '0;
        tick();
        chk_cnt++;
        if (stray !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL stray_set got stray=%b ov=%b want 1 0",
                     stray, out_valid);
        else pass_cnt++;
        start_job(16'd0);
        chk_cnt++;
        if (stray !== 1'b0 || busy !== 1'b1 || overflow !== 1'b0)
            $display("FAIL stray_clear got s=%b b=%b o=%b want 0 1 0",
                     stray, busy, overflow);
        else pass_cnt++;
        chk_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL stray_nobuf got %b want 0", out_valid);
        else pass_cnt++;
        e = {32'h7, 32'h5, 32'h3, 32'h1};
        exp_rows[0] = e;
        stream(1, 0);
        chk_cnt++;
        if (cap_q.size() != 1 || cap_q[0] !== e || cap_cyc[0] != 4)
            $display("FAIL rows0_data got n=%0d want %h at cyc 4",
                     cap_q.size(), e);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc != 5)
            $display("FAIL rows0_done got %0d want 5", done_cyc);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_job();
        row_t e;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++)
                exp_rows[k][c] = 32'hdead0000 + 32'(16 * k + c);
        start_job(16'd4);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            col_valid = '0;
            col_data  = '0;
            for (int c = 0; c < 4; c++) begin
                if (cyc - c >= 0 && cyc - c < 2) begin
                    col_valid[c] = 1'b1;
                    col_data[c]  = exp_rows[cyc-c][c];
                end
            end
            tick();
        end
        col_valid = '0;
        col_data  = '0;
        chk_cnt++;
        if (busy !== 1'b1 || out_data[0] !== 32'hdead0000)
            $display("FAIL mid_pre got busy=%b d0=%h want 1 dead0000",
                     busy, out_data[0]);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL mid_async got b=%b v=%b d=%b want 0 0 0",
                     busy, out_valid, done);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== '0 || overflow !== 1'b0 || stray !== 1'b0)
            $display("FAIL mid_async_data got %h want 0", out_data);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        e = {32'd444, 32'd333, 32'd222, 32'd111};
        exp_rows[0] = e;
        start_job(16'd1);
        stream(1, 0);
        chk_cnt++;
        if (cap_q.size() != 1 || cap_q[0] !== e || cap_cyc[0] != 4)
            $display("FAIL mid_after got n=%0d want %h at cyc 4",
                     cap_q.size(), e);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc != 5)
            $display("FAIL mid_after_done got %0d want 5", done_cyc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_streaming();
        test_back_pressure();
        test_overflow();
        test_stray_cfg();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
